// File: rtl/unidade_load_store_pkg.sv
// Shared definitions for the load/store unit: default widths and FSM encoding.
package unidade_load_store_pkg;

    localparam int LSU_DATA_W    = 8;
    localparam int LSU_ADDR_W    = 8;
    localparam int LSU_DEPTH     = 4;
    localparam int LSU_MEM_WORDS = 24;

    // ST_RESP keeps the 2-bit encoding complete; responses are issued while
    // the FSM is already back in ST_IDLE, so it is never entered.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RESP     = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/unidade_load_store_fifo_escrita.sv
// Store buffer: DEPTH-entry FIFO of {addr,data} with a combinational
// youngest-match search and a look-ahead view of the next head entry.
module unidade_load_store_fifo_escrita
    import unidade_load_store_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DEPTH  = LSU_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [ADDR_W-1:0]        push_addr_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_nxt_o,
    output logic [ADDR_W-1:0]        head_nxt_addr_o,
    output logic [DATA_W-1:0]        head_nxt_data_o,
    input  logic [ADDR_W-1:0]        srch_addr_i,
    output logic                     srch_hit_o,
    output logic [DATA_W-1:0]        srch_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_C) || do_pop);

    assign count_o     = count_q;
    assign count_nxt_o = count_d;

    // Pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state: pointers and count, cleared by reset (pending stores discarded).
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head as it will be after this edge; an entry pushed into an emptying buffer bypasses storage.
    always_comb begin
        head_nxt_addr_o = addr_q[rd_ptr_d];
        head_nxt_data_o = data_q[rd_ptr_d];
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_nxt_addr_o = push_addr_i;
            head_nxt_data_o = push_data_i;
        end
    end

    // Walk valid entries oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = rd_ptr_q;
        srch_hit_o  = 1'b0;
        srch_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == srch_addr_i)) begin
                srch_hit_o  = 1'b1;
                srch_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit in front of the data memory: buffers stores, drains them
// one per cycle, serves loads by forwarding or by a one-cycle memory read.
module unidade_load_store
    import unidade_load_store_pkg::*;
#(
    parameter int DATA_W    = LSU_DATA_W,
    parameter int ADDR_W    = LSU_ADDR_W,
    parameter int DEPTH     = LSU_DEPTH,
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              buf_empty,
    output logic [ADDR_W-1:0] mem_label,
    output logic [DATA_W-1:0] mem_dado,
    output logic              mem_LerMemo,
    output logic              mem_EscrMemo,
    input  logic [DATA_W-1:0] mem_dadoEscrito
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]  LIMIT_C = (ADDR_W + 1)'(MEM_WORDS);

    lsu_state_e        state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] mem_label_q, mem_label_d;
    logic [DATA_W-1:0] mem_dado_q, mem_dado_d;
    logic              mem_ler_q, mem_ler_d;
    logic              mem_escr_q, mem_escr_d;

    logic [CNT_W-1:0]  count, count_nxt;
    logic [ADDR_W-1:0] head_nxt_addr;
    logic [DATA_W-1:0] head_nxt_data;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              accept, in_range, push;

    // Ready depends on registered state only, never on the request inputs.
    assign req_ready = (state_q == ST_IDLE) && (count != FULL_C);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < LIMIT_C;
    assign push      = accept && req_write && in_range;
    assign buf_empty = (count == '0) && (state_q == ST_IDLE);

    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_data    = resp_data_q;
    assign mem_label    = mem_label_q;
    assign mem_dado     = mem_dado_q;
    assign mem_LerMemo  = mem_ler_q;
    assign mem_EscrMemo = mem_escr_q;

    // A drain write is on the pins for exactly one cycle, so its presence is the pop.
    unidade_load_store_fifo_escrita #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk             (clk),
        .reset           (reset),
        .push_i          (push),
        .push_addr_i     (req_addr),
        .push_data_i     (req_wdata),
        .pop_i           (mem_escr_q),
        .count_o         (count),
        .count_nxt_o     (count_nxt),
        .head_nxt_addr_o (head_nxt_addr),
        .head_nxt_data_o (head_nxt_data),
        .srch_addr_i     (req_addr),
        .srch_hit_o      (fwd_hit),
        .srch_data_o     (fwd_data)
    );

    // Next state, response and memory-pin decisions for the coming cycle.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
        mem_label_d  = '0;
        mem_dado_d   = '0;
        mem_ler_d    = 1'b0;
        mem_escr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        if (fwd_hit) begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = fwd_data;
                        end else begin
                            state_d = ST_RD_ISSUE;
                        end
                    end
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                resp_data_d  = mem_dadoEscrito;
            end
            default: state_d = ST_IDLE;
        endcase

        // The read slot wins the pins; the drain waits one cycle behind it.
        if (state_d == ST_RD_ISSUE) begin
            mem_ler_d   = 1'b1;
            mem_label_d = req_addr;
        end else if (count_nxt != '0) begin
            mem_escr_d  = 1'b1;
            mem_label_d = head_nxt_addr;
            mem_dado_d  = head_nxt_data;
        end
    end

    // FSM, response and memory-pin registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_label_q  <= '0;
            mem_dado_q   <= '0;
            mem_ler_q    <= 1'b0;
            mem_escr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            mem_label_q  <= mem_label_d;
            mem_dado_q   <= mem_dado_d;
            mem_ler_q    <= mem_ler_d;
            mem_escr_q   <= mem_escr_d;
        end
    end

endmodule

// File: tb/tb_unidade_load_store.sv
// Bench for unidade_load_store: behavioural data memory, architectural
// reference memory, queue of accepted-but-unwritten stores, expected responses.
module tb_unidade_load_store;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       err;
    } resp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } st_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       buf_empty;
    logic [7:0] mem_label;
    logic [7:0] mem_dado;
    logic       mem_LerMemo;
    logic       mem_EscrMemo;
    logic [7:0] mem_dadoEscrito;

    logic [7:0] tb_mem  [24];
    logic [7:0] ref_mem [24];
    st_t        pend_q[$];
    resp_t      exp_q[$];

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rd_due = 0;
    int         exp_rd_cyc = -1;
    logic [7:0] exp_rd_addr = 8'd0;
    bit         acc_seen = 1'b0;
    int         ler_cnt = 0;
    logic [7:0] last_data = 8'd0;
    logic       last_err = 1'b0;

    unidade_load_store dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .buf_empty       (buf_empty),
        .mem_label       (mem_label),
        .mem_dado        (mem_dado),
        .mem_LerMemo     (mem_LerMemo),
        .mem_EscrMemo    (mem_EscrMemo),
        .mem_dadoEscrito (mem_dadoEscrito)
    );

    always #5 clk = ~clk;

    // Data memory model: reloads a known pattern while reset is low, registered read.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 24; i++) tb_mem[i] <= 8'(8'h30 + i);
        end else begin
            if (mem_EscrMemo && (mem_label < 8'd24)) tb_mem[mem_label[4:0]] <= mem_dado;
            if (mem_LerMemo) mem_dadoEscrito <= (mem_label < 8'd24) ? tb_mem[mem_label[4:0]] : 8'h00;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 20000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, check, update the model, advance.
    task automatic step();
        logic ler_exp;
        logic due;
        logic hit;
        @(negedge clk);
        ler_exp = (cyc == exp_rd_cyc);
        chk("rd_wr_exclusive", 32'(mem_LerMemo & mem_EscrMemo), 32'd0);
        chk("req_ready", 32'(req_ready), 32'((cyc >= rd_due) && (pend_q.size() < 4)));
        chk("buf_empty", 32'(buf_empty), 32'((cyc >= rd_due) && (pend_q.size() == 0)));
        chk("mem_LerMemo", 32'(mem_LerMemo), 32'(ler_exp));
        if (mem_LerMemo) begin
            ler_cnt++;
            chk("rd_label", 32'(mem_label), 32'(exp_rd_addr));
        end
        chk("mem_EscrMemo", 32'(mem_EscrMemo), 32'(!ler_exp && (pend_q.size() != 0)));

        due = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        chk("resp_valid", 32'(resp_valid), 32'(due));
        if (resp_valid) begin
            last_data = resp_data;
            last_err  = resp_err;
        end
        if (due) begin
            chk("resp_data", 32'(resp_data), 32'(exp_q[0].data));
            chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
            void'(exp_q.pop_front());
        end

        acc_seen = req_valid && req_ready;
        if (acc_seen) begin
            if (req_addr >= 8'd24) begin
                exp_q.push_back('{cyc + 1, 8'h00, 1'b1});
            end else if (!req_write) begin
                hit = 1'b0;
                for (int k = pend_q.size() - 1; k >= 0; k--)
                    if (pend_q[k].a == req_addr) hit = 1'b1;
                if (hit) begin
                    exp_q.push_back('{cyc + 1, ref_mem[req_addr[4:0]], 1'b0});
                end else begin
                    exp_q.push_back('{cyc + 3, ref_mem[req_addr[4:0]], 1'b0});
                    rd_due      = cyc + 3;
                    exp_rd_cyc  = cyc + 1;
                    exp_rd_addr = req_addr;
                end
            end
        end

        if (mem_EscrMemo && (pend_q.size() != 0)) begin
            chk("drain_label", 32'(mem_label), 32'(pend_q[0].a));
            chk("drain_dado", 32'(mem_dado), 32'(pend_q[0].d));
            void'(pend_q.pop_front());
        end
        if (acc_seen && req_write && (req_addr < 8'd24)) begin
            pend_q.push_back('{req_addr, req_wdata});
            ref_mem[req_addr[4:0]] = req_wdata;
        end

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic req(input logic wr, input logic [7:0] a, input logic [7:0] d);
        bit got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            got = acc_seen;
        end
        if (!got) chk("req_accept_timeout", 32'(got), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic quiet();
        bit done;
        done = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if ((pend_q.size() == 0) && (exp_q.size() == 0) && (cyc >= rd_due)) done = 1'b1;
            else step();
        end
        if (!done) chk("quiet_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset     = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b1;
        pend_q.delete();
        exp_q.delete();
        rd_due     = 0;
        exp_rd_cyc = -1;
        for (int i = 0; i < 24; i++) ref_mem[i] = 8'(8'h30 + i);
    endtask

    initial begin
        int l0;
        logic [7:0] a;

        // Reset state
        do_reset();
        chk("rst_mem_label", 32'(mem_label), 32'd0);
        chk("rst_mem_dado", 32'(mem_dado), 32'd0);
        chk("rst_LerMemo", 32'(mem_LerMemo), 32'd0);
        chk("rst_EscrMemo", 32'(mem_EscrMemo), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_buf_empty", 32'(buf_empty), 32'd1);
        idle(2);

        // Store then load after drain: memory read path
        req(1'b1, 8'd5, 8'hA5);
        quiet();
        req(1'b0, 8'd5, 8'h00);
        quiet();
        chk("t2_load5_data", 32'(last_data), 32'hA5);

        // Back-to-back stores to one address, immediate load forwards the younger one
        l0 = ler_cnt;
        req(1'b1, 8'd3, 8'h11);
        req(1'b1, 8'd3, 8'h22);
        req(1'b0, 8'd3, 8'h00);
        quiet();
        chk("t3_fwd_data", 32'(last_data), 32'h22);
        chk("t3_no_read", 32'(ler_cnt), 32'(l0));

        // Five gapless stores, drained in order
        for (int k = 0; k < 5; k++) req(1'b1, 8'(10 + k), 8'(k * 17 + 1));
        quiet();
        chk("t4_mem14", 32'(tb_mem[14]), 32'h45);

        // Load miss right behind pending stores
        req(1'b1, 8'd8, 8'h88);
        req(1'b1, 8'd9, 8'h99);
        req(1'b0, 8'd7, 8'h00);
        quiet();
        chk("t5_miss_data", 32'(last_data), 32'h37);

        // Out-of-range load and store
        l0 = ler_cnt;
        req(1'b0, 8'd24, 8'h00);
        quiet();
        chk("t6_load_err", 32'(last_err), 32'd1);
        chk("t6_load_err_data", 32'(last_data), 32'd0);
        req(1'b1, 8'd24, 8'h55);
        quiet();
        chk("t6_store_err", 32'(last_err), 32'd1);
        chk("t6_no_read", 32'(ler_cnt), 32'(l0));

        // Reset during RD_WAIT, then during a drain
        req(1'b0, 8'd12, 8'h00);
        step();
        do_reset();
        chk("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_rst_buf_empty", 32'(buf_empty), 32'd1);
        idle(3);
        req(1'b1, 8'd2, 8'h99);
        do_reset();
        chk("t6_rst2_EscrMemo", 32'(mem_EscrMemo), 32'd0);
        idle(2);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 27)) : 8'($urandom_range(0, 3));
                req(1'($urandom_range(0, 1)), a, 8'($urandom));
            end
        end
        quiet();
        for (int i = 0; i < 24; i++) chk($sformatf("final_mem[%0d]", i), 32'(tb_mem[i]), 32'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
